// File: rtl/vsqrt_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// vsqrt_issue_ctrl_if
//   Bundles the three handshakes around the FP16 square-root issue
//   controller: the vector request port, the vector response port and the
//   element stream to and from the pipelined sqrt functional unit.
//
//   Signals (all sampled on the rising edge of the controller clock):
//     req_valid/req_ready/req_data        request vector, lane i at [16i+15:16i]
//     resp_valid/resp_ready/resp_data     result vector, same lane packing
//     resp_error                          response was closed by the timeout
//     fu_valid_in/fu_input                one operand per cycle into the unit
//     fu_valid_out/fu_output              in-order results from the unit
//
//   Modports:
//     slave  - the controller (accepts requests, drives the sqrt unit)
//     master - the surroundings (dispatch stage, consumer, sqrt unit)
// ---------------------------------------------------------------------------
interface vsqrt_issue_ctrl_if #(
  parameter int LANES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [16*LANES-1:0]   req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [16*LANES-1:0]   resp_data;
  logic                  resp_error;
  logic                  fu_valid_in;
  logic [15:0]           fu_input;
  logic                  fu_valid_out;
  logic [15:0]           fu_output;

  modport slave (
    input  req_valid, req_data, resp_ready, fu_valid_out, fu_output,
    output req_ready, resp_valid, resp_data, resp_error, fu_valid_in, fu_input
  );

  modport master (
    output req_valid, req_data, resp_ready, fu_valid_out, fu_output,
    input  req_ready, resp_valid, resp_data, resp_error, fu_valid_in, fu_input
  );
endinterface

// File: rtl/vsqrt_issue_ctrl.sv
// ---------------------------------------------------------------------------
// vsqrt_issue_ctrl
//   Initiator-side controller for the pipelined FP16 square-root unit.
//   Takes one vector of LANES FP16 operands, streams them into the unit one
//   per cycle, gathers the in-order results, replaces the results of
//   operands the unit does not handle (negatives, +-0, +-inf, NaN) with the
//   IEEE answer, and hands the vector back. One vector in flight at a time.
//
//   Ports:
//     CLK   rising-edge clock
//     nRST  asynchronous active-low reset
//     bus   vsqrt_issue_ctrl_if.slave: request, response and sqrt-unit streams
//     busy  high whenever the controller is not idle
//
//   Parameters:
//     LANES    FP16 elements per request (>= 1)
//     TIMEOUT  cycles allowed in DRAIN before missing results are abandoned
// ---------------------------------------------------------------------------
module vsqrt_issue_ctrl #(
  parameter int LANES   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  vsqrt_issue_ctrl_if.slave bus,
  output logic              busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;  // lane select width
  localparam int CW = $clog2(LANES + 1);                // collect count 0..LANES
  localparam int TW = $clog2(TIMEOUT + 1);              // timeout counter width
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t            state_reg;
  logic [15:0]       op_reg       [LANES];
  logic [15:0]       res_reg      [LANES];
  logic [15:0]       spec_val_reg [LANES];
  logic [LANES-1:0]  spec_flag_reg;
  logic [IW-1:0]     issue_idx_reg;
  logic [CW-1:0]     collect_idx_reg;
  logic [TW-1:0]     tmo_cnt_reg;
  logic              err_reg;
  logic              fu_valid_in_reg;
  logic [15:0]       fu_input_reg;

  // Operands the unit cannot be trusted with: any sign-set value (covers
  // -0, negative numbers, -inf, negative NaN), +0, +inf and every NaN.
  function automatic logic lane_is_special(input logic [15:0] x);
    return x[15] || (x[14:0] == 15'h0000) || (x == 16'h7C00) ||
           ((x[14:10] == 5'h1F) && (x[9:0] != 10'h000));
  endfunction

  // sqrt(+-0) keeps the sign, sqrt(+inf) = +inf, everything else is a qNaN.
  function automatic logic [15:0] lane_special_value(input logic [15:0] x);
    if (x[14:0] == 15'h0000)
      return x;
    else if (x == 16'h7C00)
      return 16'h7C00;
    else
      return QNAN;
  endfunction

  // Per-lane decode of the incoming vector, used only at the accept edge.
  logic [15:0]      req_lane     [LANES];
  logic [15:0]      req_spec_val [LANES];
  logic [LANES-1:0] req_spec_flag;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign req_lane[gi]      = bus.req_data[16*gi +: 16];
      assign req_spec_flag[gi] = lane_is_special(req_lane[gi]);
      assign req_spec_val[gi]  = lane_special_value(req_lane[gi]);
      assign bus.resp_data[16*gi +: 16] = res_reg[gi];
    end
  endgenerate

  // Result collection. Results are accepted in ISSUE as well as DRAIN so a
  // short-latency unit answering during the last issue cycle is not lost.
  logic          collect_en;
  logic          last_collect;
  logic [IW-1:0] col_sel;
  logic [15:0]   collect_val;
  logic [CW-1:0] cidx_after;

  assign col_sel      = collect_idx_reg[IW-1:0];
  assign collect_en   = ((state_reg == ISSUE) || (state_reg == DRAIN)) &&
                        bus.fu_valid_out && (collect_idx_reg < CW'(LANES));
  assign last_collect = collect_en && (collect_idx_reg == CW'(LANES - 1));
  assign collect_val  = spec_flag_reg[col_sel] ? spec_val_reg[col_sel] : bus.fu_output;
  // First lane still empty after this cycle's collect; the timeout fills from here.
  assign cidx_after   = collect_idx_reg + CW'(collect_en);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      spec_flag_reg   <= '0;
      issue_idx_reg   <= '0;
      collect_idx_reg <= '0;
      tmo_cnt_reg     <= '0;
      err_reg         <= 1'b0;
      fu_valid_in_reg <= 1'b0;
      fu_input_reg    <= '0;
      for (int i = 0; i < LANES; i++) begin
        op_reg[i]       <= '0;
        res_reg[i]      <= '0;
        spec_val_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            for (int i = 0; i < LANES; i++) begin
              op_reg[i]       <= req_lane[i];
              spec_val_reg[i] <= req_spec_val[i];
            end
            spec_flag_reg   <= req_spec_flag;
            issue_idx_reg   <= '0;
            collect_idx_reg <= '0;
            tmo_cnt_reg     <= '0;
            err_reg         <= 1'b0;
            // Lane 0 goes out in the very next cycle.
            fu_valid_in_reg <= 1'b1;
            fu_input_reg    <= req_lane[0];
            state_reg       <= ISSUE;
          end
        end

        ISSUE: begin
          // issue_idx_reg names the lane currently on fu_input.
          if (issue_idx_reg == IW'(LANES - 1)) begin
            fu_valid_in_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
            state_reg       <= DRAIN;
          end else begin
            issue_idx_reg <= issue_idx_reg + IW'(1);
            fu_input_reg  <= op_reg[issue_idx_reg + IW'(1)];
          end
          if (last_collect) begin
            fu_valid_in_reg <= 1'b0;
            state_reg       <= RESP;
          end
        end

        DRAIN: begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          if (last_collect) begin
            state_reg <= RESP;
          end else if (tmo_cnt_reg + TW'(1) == TW'(TIMEOUT)) begin
            err_reg <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
              if (CW'(i) >= cidx_after)
                res_reg[i] <= QNAN;
            end
            state_reg <= RESP;
          end
        end

        RESP: begin
          if (bus.resp_ready)
            state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase

      if (collect_en) begin
        res_reg[col_sel] <= collect_val;
        collect_idx_reg  <= collect_idx_reg + CW'(1);
      end
    end
  end

  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.resp_valid  = (state_reg == RESP);
  assign bus.resp_error  = err_reg;
  assign bus.fu_valid_in = fu_valid_in_reg;
  assign bus.fu_input    = fu_input_reg;
  assign busy            = (state_reg != IDLE);

endmodule
